// File: rtl/spi_audio_tx.sv
// ---------------------------------------------------------------------------
// spi_audio_tx
//
// Buffers multichannel PCM frames in a small FIFO and serialises them to an
// MCU acting as SPI master (mode 0: MCU samples on sck rise, data changes on
// sck fall). The MCU clock is asynchronous to clk, so sck is oversampled
// through a synchronizer and its edges are detected in the clk domain.
//
// Parameters
//   DATA_W      bits per channel sample
//   NUM_CH      channels per frame (FRAME_W = NUM_CH*DATA_W)
//   FIFO_DEPTH  frames buffered, power of two and >= 2
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   pcm_in       frame, channel 0 in the most significant DATA_W bits
//   audio_valid  one-cycle strobe qualifying pcm_in
//   sck          SPI clock from the MCU (asynchronous)
//   sdo          serial data to the MCU, MSB first
//   drdy         frame loaded and awaiting clocking (MCU interrupt)
//   overflow     sticky flag, a frame was dropped on a full FIFO
//   fifo_level   number of frames currently held in the FIFO
// ---------------------------------------------------------------------------
module spi_audio_tx #(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CH*DATA_W-1:0]         pcm_in,
    input  logic                             audio_valid,
    input  logic                             sck,
    output logic                             sdo,
    output logic                             drdy,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q,     state_d;
    logic [FRAME_W-1:0]   shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]     bit_count_q, bit_count_d;

    logic [FRAME_W-1:0]   mem_q [FIFO_DEPTH];
    logic [FRAME_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]     count_q,     count_d;
    logic                 overflow_q,  overflow_d;

    logic                 sck_s1_q,    sck_s1_d;
    logic                 sck_s2_q,    sck_s2_d;
    logic                 sck_prev_q,  sck_prev_d;

    logic                 sck_rise;
    logic                 sck_fall;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_comb begin
        sck_s1_d   = sck;
        sck_s2_d   = sck_s1_q;
        sck_prev_d = sck_s2_q;
    end

    assign sck_rise = sck_s2_q & ~sck_prev_q;
    assign sck_fall = ~sck_s2_q & sck_prev_q;

    // Transmit FSM. LOAD is the only pop point, so a frame leaves the FIFO
    // exactly once and the shift register always holds a whole frame.
    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_count_d = bit_count_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop         = 1'b1;
                shift_reg_d = mem_q[rd_ptr_q];
                bit_count_d = '0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                // The rise that completes the frame ends it; the trailing
                // fall is then ignored outside SHIFT.
                if (sck_rise) begin
                    bit_count_d = bit_count_q + CNT_W'(1);
                    if (bit_count_q == CNT_W'(FRAME_W - 1)) begin
                        state_d = DONE;
                    end
                end else if (sck_fall) begin
                    shift_reg_d = shift_reg_q << 1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. A full FIFO still accepts a push when the FSM pops
    // in the same cycle, so only an unmatched push on full is dropped.
    always_comb begin
        fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
        push       = audio_valid & (~fifo_full | pop);
        drop       = audio_valid & fifo_full & ~pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;

        if (push) begin
            mem_d[wr_ptr_q] = pcm_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any frame in flight and the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_prev_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_count_q <= bit_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_prev_q  <= sck_prev_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign drdy       = (state_q == SHIFT);
    assign sdo        = drdy ? shift_reg_q[FRAME_W-1] : 1'b0;
    assign overflow   = overflow_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_spi_audio_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_audio_tx
//
// Drives two spi_audio_tx instances: the default configuration (32-bit
// frames, 4-deep FIFO) checked cycle by cycle against a frame-level model,
// and a 24-bit single-channel configuration checked with literal values.
// ---------------------------------------------------------------------------
module tb_spi_audio_tx;

    localparam int FW = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pcm_in;
    logic        audio_valid;
    logic        sck;
    logic        sdo;
    logic        drdy;
    logic        overflow;
    logic [2:0]  fifo_level;

    logic [23:0] pcm_in2;
    logic        audio_valid2;
    logic        sck2;
    logic        sdo2;
    logic        drdy2;
    logic        overflow2;
    logic [1:0]  fifo_level2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_audio_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pcm_in      (pcm_in),
        .audio_valid (audio_valid),
        .sck         (sck),
        .sdo         (sdo),
        .drdy        (drdy),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    spi_audio_tx #(
        .DATA_W     (24),
        .NUM_CH     (1),
        .FIFO_DEPTH (2)
    ) dut24 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pcm_in      (pcm_in2),
        .audio_valid (audio_valid2),
        .sck         (sck2),
        .sdo         (sdo2),
        .drdy        (drdy2),
        .overflow    (overflow2),
        .fifo_level  (fifo_level2)
    );

    // Compare one value and keep the running tallies.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the default instance's frame strobe for the coming clk edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] frame);
        @(negedge clk);
        audio_valid = valid;
        pcm_in      = frame;
    endtask

    // Frame-level model of the default instance. Time is tracked as a cycle
    // number: the engine is free from free_at on, a frame seen waiting while
    // free is taken one cycle later, and a finished frame leaves a DONE and
    // an IDLE cycle before the engine looks again.
    int          m_cyc     = 0;
    int          m_free_at = 0;
    int          m_pop_at  = -1;
    int          m_rises   = 0;
    bit          m_sending = 1'b0;
    bit          m_ovf     = 1'b0;
    bit          m_s1      = 1'b0;
    bit          m_s2      = 1'b0;
    bit          m_prev    = 1'b0;
    bit          m_live    = 1'b0;
    logic [31:0] m_frame   = '0;
    logic [31:0] m_q[$];

    task automatic modelStep();
        bit rise;
        bit fall;
        bit popping;
        int size0;
        if (!reset_n) begin
            m_q.delete();
            m_sending = 1'b0;
            m_pop_at  = -1;
            m_free_at = m_cyc + 1;
            m_ovf     = 1'b0;
            m_s1      = 1'b0;
            m_s2      = 1'b0;
            m_prev    = 1'b0;
            m_rises   = 0;
            m_frame   = '0;
            m_live    = 1'b1;
        end else begin
            rise    = m_s2 & ~m_prev;
            fall    = ~m_s2 & m_prev;
            popping = (m_pop_at == m_cyc);
            size0   = m_q.size();
            if (m_sending) begin
                if (rise) begin
                    m_rises++;
                    if (m_rises == FW) begin
                        m_sending = 1'b0;
                        m_free_at = m_cyc + 2;
                    end
                end else if (fall) begin
                    m_frame = m_frame << 1;
                end
            end
            if (popping) begin
                m_frame   = m_q.pop_front();
                m_rises   = 0;
                m_sending = 1'b1;
                m_pop_at  = -1;
            end else if (!m_sending && m_pop_at < 0 && m_cyc >= m_free_at && size0 > 0) begin
                m_pop_at = m_cyc + 1;
            end
            if (audio_valid) begin
                if (size0 < 4 || popping) begin
                    m_q.push_back(pcm_in);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = sck;
        end
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every cycle, the default instance's outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                checkOutput("model_drdy", 32'(drdy), 32'(m_sending));
                checkOutput("model_sdo", 32'(sdo), 32'(m_sending ? m_frame[31] : 1'b0));
                checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
                checkOutput("model_level", 32'(fifo_level), 32'(m_q.size()));
            end
        end
    end

    // Wait, bounded, for drdy on the selected instance.
    task automatic waitDrdy(input int sel);
        int n;
        n = 0;
        while (n < 20 && !(sel == 0 ? drdy : drdy2)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drdy_wait", 32'(sel == 0 ? drdy : drdy2), 32'd1);
    endtask

    // Behave like the MCU: sample sdo, raise sck for 4 clks, lower it for 4.
    // With end_check set, the last rise must be the one that drops drdy.
    task automatic clockFrame(input int sel, input int nbits, input bit end_check,
                              output logic [31:0] got);
        logic bitv;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (end_check && i == nbits - 1) begin
                checkOutput("drdy_before_last", 32'(sel == 0 ? drdy : drdy2), 32'd1);
            end
            bitv = (sel == 0) ? sdo : sdo2;
            got  = {got[30:0], bitv};
            if (sel == 0) sck = 1'b1; else sck2 = 1'b1;
            repeat (4) @(negedge clk);
            if (end_check && i == nbits - 1) begin
                checkOutput("drdy_after_last", 32'(sel == 0 ? drdy : drdy2), 32'd0);
            end
            if (sel == 0) sck = 1'b0; else sck2 = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] got;
    int          n;

    initial begin
        reset_n      = 1'b0;
        pcm_in       = '0;
        audio_valid  = 1'b0;
        sck          = 1'b0;
        pcm_in2      = '0;
        audio_valid2 = 1'b0;
        sck2         = 1'b0;

        // Reset values on both instances.
        repeat (2) @(negedge clk);
        checkOutput("reset_drdy", 32'(drdy), 32'd0);
        checkOutput("reset_sdo", 32'(sdo), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_level", 32'(fifo_level), 32'd0);
        checkOutput("reset24_drdy", 32'(drdy2), 32'd0);
        checkOutput("reset24_level", 32'(fifo_level2), 32'd0);
        reset_n = 1'b1;

        // sck activity while idle with nothing queued changes nothing.
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        checkOutput("idle_sdo", 32'(sdo), 32'd0);
        checkOutput("idle_drdy", 32'(drdy), 32'd0);
        checkOutput("idle_bit_count", 32'(dut.bit_count_q), 32'd0);

        // Single frame from idle: drdy at N+3, bits MSB first.
        applyStimulus(1'b1, 32'hABCD_1234);
        applyStimulus(1'b0, 32'h0);
        checkOutput("latency_n1", 32'(drdy), 32'd0);
        @(negedge clk);
        checkOutput("latency_n2", 32'(drdy), 32'd0);
        @(negedge clk);
        checkOutput("latency_n3", 32'(drdy), 32'd1);
        clockFrame(0, 32, 1'b1, got);
        checkOutput("frame_abcd1234", got, 32'hABCD_1234);

        // Five back-to-back pushes, then a sixth into a full FIFO.
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 + 32'(i));
            if (i == 4) begin
                checkOutput("level_after4", 32'(fifo_level), 32'd3);
            end
        end
        applyStimulus(1'b0, 32'h0);
        checkOutput("level_after5", 32'(fifo_level), 32'd4);
        checkOutput("overflow_after5", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 32'hDEAD_0006);
        applyStimulus(1'b0, 32'h0);
        checkOutput("overflow_after6", 32'(overflow), 32'd1);
        checkOutput("level_after6", 32'(fifo_level), 32'd4);

        // Push on the pop cycle of a full FIFO is accepted.
        pulseReset();
        applyStimulus(1'b1, 32'hF0F0_F0F0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b1, 32'h2000_0000 + 32'(i));
        end
        applyStimulus(1'b0, 32'h0);
        waitDrdy(0);
        checkOutput("full_level", 32'(fifo_level), 32'd4);
        clockFrame(0, 31, 1'b0, got);
        checkOutput("first_31_bits", got, 32'h7878_7878);
        sck = 1'b1;
        n = 0;
        while (drdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 32'(drdy), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h55AA_55AA);
        applyStimulus(1'b0, 32'h0);
        checkOutput("poppush_overflow", 32'(overflow), 32'd0);
        checkOutput("poppush_level", 32'(fifo_level), 32'd4);
        sck = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-frame with two frames queued, then a clean frame.
        pulseReset();
        applyStimulus(1'b1, 32'h1111_2222);
        applyStimulus(1'b0, 32'h0);
        waitDrdy(0);
        applyStimulus(1'b1, 32'h3333_4444);
        applyStimulus(1'b1, 32'h5555_6666);
        applyStimulus(1'b0, 32'h0);
        clockFrame(0, 10, 1'b0, got);
        checkOutput("partial_10_bits", got, 32'h0000_0044);
        checkOutput("queued_level", 32'(fifo_level), 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("midreset_drdy", 32'(drdy), 32'd0);
        checkOutput("midreset_sdo", 32'(sdo), 32'd0);
        checkOutput("midreset_overflow", 32'(overflow), 32'd0);
        checkOutput("midreset_level", 32'(fifo_level), 32'd0);
        applyStimulus(1'b1, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0);
        waitDrdy(0);
        clockFrame(0, 32, 1'b1, got);
        checkOutput("frame_after_reset", got, 32'h1234_5678);

        // 24-bit single-channel instance.
        @(negedge clk);
        audio_valid2 = 1'b1;
        pcm_in2      = 24'h80_0001;
        @(negedge clk);
        audio_valid2 = 1'b0;
        waitDrdy(1);
        clockFrame(1, 24, 1'b1, got);
        checkOutput("frame24_800001", got, 32'h0080_0001);
        checkOutput("frame24_overflow", 32'(overflow2), 32'd0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
